// File: rtl/conv_column_feeder.sv
// Raster pixel stream to 3-pixel vertical columns via two line buffers, plus 9-byte kernel serialiser.
// Latency 1 cycle accept-to-strobe; no backpressure input, acceptance gated by registered o_ready.
module conv_column_feeder #(
    parameter int BIT_LEN    = 8,
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic               CLK100MHZ,
    input  logic               i_reset,
    input  logic [BIT_LEN-1:0] i_pixel,
    input  logic               i_pixel_valid,
    input  logic               i_kernel_load,
    input  logic               i_start,
    output logic               o_ready,
    output logic [BIT_LEN-1:0] o_dato0,
    output logic [BIT_LEN-1:0] o_dato1,
    output logic [BIT_LEN-1:0] o_dato2,
    output logic               o_selecK_I,
    output logic               o_valid,
    output logic               o_frame_done
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [ROW_W-1:0] ROW_FIRST_OUT = ROW_W'(2);

    typedef enum logic [1:0] {IDLE, KLOAD, STREAM} state_t;

    state_t             state;
    logic [COL_W-1:0]   col_cnt;
    logic [ROW_W-1:0]   row_cnt;
    logic [3:0]         kcnt;
    logic [BIT_LEN-1:0] kbuf0;
    logic [BIT_LEN-1:0] kbuf1;

    logic [BIT_LEN-1:0] lb0 [IMG_WIDTH];
    logic [BIT_LEN-1:0] lb1 [IMG_WIDTH];
    logic [BIT_LEN-1:0] rd0;
    logic [BIT_LEN-1:0] rd1;

    logic accept;
    logic stream_acc;
    logic kload_acc;
    logic kbyte_first;
    logic kbyte_second;

    assign accept       = i_pixel_valid && o_ready;
    assign stream_acc   = accept && (state == STREAM);
    assign kload_acc    = accept && (state == KLOAD);
    assign kbyte_first  = (kcnt == 4'd0) || (kcnt == 4'd3) || (kcnt == 4'd6);
    assign kbyte_second = (kcnt == 4'd1) || (kcnt == 4'd4) || (kcnt == 4'd7);
    assign rd0          = lb0[col_cnt];
    assign rd1          = lb1[col_cnt];

    // Line buffers carry no reset; rows 0 and 1 overwrite every entry before any column is emitted.
    always_ff @(posedge CLK100MHZ) begin
        if (stream_acc) begin
            lb0[col_cnt] <= rd1;
            lb1[col_cnt] <= i_pixel;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge i_reset) begin
        if (!i_reset) begin
            state        <= IDLE;
            col_cnt      <= '0;
            row_cnt      <= '0;
            kcnt         <= '0;
            kbuf0        <= '0;
            kbuf1        <= '0;
            o_ready      <= 1'b0;
            o_dato0      <= '0;
            o_dato1      <= '0;
            o_dato2      <= '0;
            o_selecK_I   <= 1'b1;
            o_valid      <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_valid      <= 1'b0;
            o_frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_kernel_load) begin
                        state   <= KLOAD;
                        kcnt    <= '0;
                        o_ready <= 1'b1;
                    end else if (i_start) begin
                        state   <= STREAM;
                        col_cnt <= '0;
                        row_cnt <= '0;
                        o_ready <= 1'b1;
                    end
                end
                KLOAD: begin
                    if (kload_acc) begin
                        if (kbyte_first) begin
                            kbuf0 <= i_pixel;
                        end else if (kbyte_second) begin
                            kbuf1 <= i_pixel;
                        end else begin
                            o_dato0    <= kbuf0;
                            o_dato1    <= kbuf1;
                            o_dato2    <= i_pixel;
                            o_selecK_I <= 1'b0;
                            o_valid    <= 1'b1;
                        end
                        if (kcnt == 4'd8) begin
                            kcnt    <= '0;
                            state   <= IDLE;
                            o_ready <= 1'b0;
                        end else begin
                            kcnt <= kcnt + 4'd1;
                        end
                    end
                end
                STREAM: begin
                    if (stream_acc) begin
                        if (row_cnt >= ROW_FIRST_OUT) begin
                            o_dato0    <= rd0;
                            o_dato1    <= rd1;
                            o_dato2    <= i_pixel;
                            o_selecK_I <= 1'b1;
                            o_valid    <= 1'b1;
                        end
                        if (col_cnt == COL_LAST) begin
                            col_cnt <= '0;
                            if (row_cnt == ROW_LAST) begin
                                row_cnt      <= '0;
                                state        <= IDLE;
                                o_ready      <= 1'b0;
                                o_frame_done <= 1'b1;
                            end else begin
                                row_cnt <= row_cnt + 1'b1;
                            end
                        end else begin
                            col_cnt <= col_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_column_feeder.sv
// Bench for conv_column_feeder on a 4x4 frame: table-built frame vectors, queue scoreboard, reset corners.
module tb_conv_column_feeder;

    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;

    logic       clk;
    logic       i_reset;
    logic [7:0] i_pixel;
    logic       i_pixel_valid;
    logic       i_kernel_load;
    logic       i_start;
    logic       o_ready;
    logic [7:0] o_dato0;
    logic [7:0] o_dato1;
    logic [7:0] o_dato2;
    logic       o_selecK_I;
    logic       o_valid;
    logic       o_frame_done;

    conv_column_feeder #(.BIT_LEN(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .CLK100MHZ    (clk),
        .i_reset      (i_reset),
        .i_pixel      (i_pixel),
        .i_pixel_valid(i_pixel_valid),
        .i_kernel_load(i_kernel_load),
        .i_start      (i_start),
        .o_ready      (o_ready),
        .o_dato0      (o_dato0),
        .o_dato1      (o_dato1),
        .o_dato2      (o_dato2),
        .o_selecK_I   (o_selecK_I),
        .o_valid      (o_valid),
        .o_frame_done (o_frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] d2;
        logic       sel;
        logic       fd;
    } exp_t;

    typedef struct {
        logic [7:0] pix;
        bit         exp_vld;
        exp_t       e;
    } vec_t;

    vec_t fvec [N];
    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   strobes = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected columns come straight from the raster index: pixel i sits under i-4 and i-8.
    task automatic fill_frame(input logic [7:0] base);
        for (int i = 0; i < N; i++) begin
            fvec[i].pix     = base + 8'(i);
            fvec[i].exp_vld = (i / W) >= 2;
            fvec[i].e.d0    = base + 8'(i - 2 * W);
            fvec[i].e.d1    = base + 8'(i - W);
            fvec[i].e.d2    = base + 8'(i);
            fvec[i].e.sel   = 1'b1;
            fvec[i].e.fd    = (i == N - 1);
        end
    endtask

    task automatic beat(input logic [7:0] p, input bit push, input exp_t e);
        i_pixel       = p;
        i_pixel_valid = 1'b1;
        if (push) q.push_back(e);
        @(posedge clk);
        #1;
        i_pixel_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic pulse_kload;
        i_kernel_load = 1'b1;
        @(posedge clk);
        #1;
        i_kernel_load = 1'b0;
    endtask

    task automatic drain(input string name);
        idle(3);
        chk(name, q.size(), 0);
    endtask

    task automatic run_frame(input logic [7:0] base, input bit gaps);
        fill_frame(base);
        pulse_start();
        chk("frame_ready_up", int'(o_ready), 1);
        for (int i = 0; i < N; i++) begin
            beat(fvec[i].pix, fvec[i].exp_vld, fvec[i].e);
            if (gaps) idle(1);
        end
        chk("frame_ready_down", int'(o_ready), 0);
        drain("frame_pending");
    endtask

    task automatic run_kernel(input logic [7:0] base);
        exp_t e;
        for (int k = 0; k < 9; k++) begin
            e = {base + 8'(k - 2), base + 8'(k - 1), base + 8'(k), 1'b0, 1'b0};
            beat(base + 8'(k), (k % 3) == 2, e);
        end
        chk("kload_ready_down", int'(o_ready), 0);
        drain("kload_pending");
    endtask

    // Scoreboard: every strobe must match the oldest pending expectation; none may arrive unannounced.
    always @(negedge clk) begin
        if (i_reset) begin
            if (o_valid) begin
                strobes++;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: got %0h,%0h,%0h sel=%0b fd=%0b, none expected",
                             o_dato0, o_dato1, o_dato2, o_selecK_I, o_frame_done);
                end else begin
                    exp_t ex;
                    exp_t got;
                    ex  = q.pop_front();
                    got = {o_dato0, o_dato1, o_dato2, o_selecK_I, o_frame_done};
                    if (got !== ex) begin
                        errors++;
                        $display("FAIL strobe: got %h expected %h", got, ex);
                    end
                end
            end else if (o_frame_done) begin
                checks++;
                errors++;
                $display("FAIL frame_done_alone: got 1 expected 0");
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        i_reset       = 1'b0;
        i_pixel       = '0;
        i_pixel_valid = 1'b0;
        i_kernel_load = 1'b0;
        i_start       = 1'b1;
        idle(3);
        chk("rst_ready", int'(o_ready), 0);
        chk("rst_dato0", int'(o_dato0), 0);
        chk("rst_dato1", int'(o_dato1), 0);
        chk("rst_dato2", int'(o_dato2), 0);
        chk("rst_sel", int'(o_selecK_I), 1);
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_fd", int'(o_frame_done), 0);
        i_start = 1'b0;
        i_reset = 1'b1;
        idle(2);
        chk("post_rst_ready", int'(o_ready), 0);

        // Beats offered in IDLE are ignored.
        beat(8'hEE, 1'b0, '0);
        drain("idle_beat");
        chk("idle_ready", int'(o_ready), 0);

        pulse_kload();
        chk("kload_ready_up", int'(o_ready), 1);
        run_kernel(8'h01);
        chk("kload_hold_d2", int'(o_dato2), 8'h09);
        chk("kload_hold_sel", int'(o_selecK_I), 0);

        run_frame(8'h10, 1'b0);
        chk("frame_hold_d0", int'(o_dato0), 8'h17);
        run_frame(8'h10, 1'b1);

        i_kernel_load = 1'b1;
        i_start       = 1'b1;
        @(posedge clk);
        #1;
        i_kernel_load = 1'b0;
        i_start       = 1'b0;
        chk("both_ready_up", int'(o_ready), 1);
        run_kernel(8'hA0);
        beat(8'h55, 1'b0, '0);
        drain("both_no_stream");

        fill_frame(8'h20);
        pulse_start();
        for (int i = 0; i < 6; i++) beat(fvec[i].pix, 1'b0, '0);
        i_reset = 1'b0;
        #2;
        chk("midrst_ready", int'(o_ready), 0);
        chk("midrst_sel", int'(o_selecK_I), 1);
        @(posedge clk);
        #1;
        i_reset = 1'b1;
        idle(2);
        chk("midrst_idle_ready", int'(o_ready), 0);
        run_frame(8'h40, 1'b0);

        chk("strobe_total", strobes, 3 + 8 + 8 + 3 + 8);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
